// File: rtl/layer_compositor.sv
// Depth-keyed layer compositor: picks the nearest opaque layer (or the background map),
// maps it through the palette and applies a frame-stepped brightness fade.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 6,
    parameter int DEPTH_W    = 2,
    parameter int LVL_W      = 4,
    parameter int FADE_RATE  = 2
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          FrameStart,
    input  logic                          Blank,
    input  logic [NUM_LAYERS*IDX_W-1:0]   LayerPixel,
    input  logic [NUM_LAYERS*DEPTH_W-1:0] LayerDepth,
    input  logic [IDX_W-1:0]              BgPixel,
    input  logic                          MapForce,
    input  logic                          FadeStart,
    input  logic                          FadeDir,
    output logic                          FadeBusy,
    output logic [LVL_W:0]                FadeLevel,
    output logic [7:0]                    Red,
    output logic [7:0]                    Green,
    output logic [7:0]                    Blue
);

    localparam int             CNT_W    = $clog2(FADE_RATE + 1);
    localparam logic [LVL_W:0] LVL_FULL = {1'b1, {LVL_W{1'b0}}};
    localparam logic [DEPTH_W-1:0] DEPTH_TOP = {DEPTH_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE_BRIGHT,
        FADING_OUT,
        IDLE_DARK,
        FADING_IN
    } fade_state_t;

    // Fixed palette ROM: each channel is a simple bit pattern of the index.
    function automatic logic [23:0] palette(input logic [IDX_W-1:0] idx);
        logic [7:0] r, g, b;
        r = 8'({idx, 2'b11});
        g = 8'({~idx, 2'b01});
        b = 8'({idx[1:0], idx});
        return {r, g, b};
    endfunction

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [LVL_W:0] lvl);
        logic [8+LVL_W:0] prod;
        prod = c * lvl;
        return 8'(prod >> LVL_W);
    endfunction

    fade_state_t      state_q, state_d;
    logic [LVL_W:0]   lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0] idx_p1_q, idx_p1_d;
    logic             blank_p1_q;
    logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;

    // Stage 1: depth-keyed layer selection.
    always_comb begin
        logic               found;
        logic [DEPTH_W-1:0] best_depth;
        logic [IDX_W-1:0]   best_idx;
        found      = 1'b0;
        best_depth = '0;
        best_idx   = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (LayerPixel[k*IDX_W +: IDX_W] != '0 &&
                (!found || LayerDepth[k*DEPTH_W +: DEPTH_W] > best_depth)) begin
                found      = 1'b1;
                best_depth = LayerDepth[k*DEPTH_W +: DEPTH_W];
                best_idx   = LayerPixel[k*IDX_W +: IDX_W];
            end
        end
        idx_p1_d = best_idx;
        if (!found || (MapForce && best_depth != DEPTH_TOP)) begin
            idx_p1_d = BgPixel;
        end
    end

    // Stage 2: palette lookup, fade scaling and blanking.
    always_comb begin
        logic [23:0] rgb;
        rgb     = palette(idx_p1_q);
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (blank_p1_q) begin
            red_d   = scale_chan(rgb[23:16], lvl_q);
            green_d = scale_chan(rgb[15:8], lvl_q);
            blue_d  = scale_chan(rgb[7:0], lvl_q);
        end
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        if (FadeStart && !FadeDir && (state_q == IDLE_BRIGHT || state_q == FADING_IN)) begin
            state_d = FADING_OUT;
            cnt_d   = '0;
        end else if (FadeStart && FadeDir && (state_q == IDLE_DARK || state_q == FADING_OUT)) begin
            state_d = FADING_IN;
            cnt_d   = '0;
        end else if (FrameStart && (state_q == FADING_OUT || state_q == FADING_IN)) begin
            if (cnt_inc == CNT_W'(FADE_RATE)) begin
                cnt_d = '0;
                if (state_q == FADING_OUT) begin
                    lvl_d = lvl_q - 1'b1;
                    if (lvl_q == (LVL_W+1)'(1)) state_d = IDLE_DARK;
                end else begin
                    lvl_d = lvl_q + 1'b1;
                    if (lvl_q == LVL_FULL - 1'b1) state_d = IDLE_BRIGHT;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE_BRIGHT;
            lvl_q      <= LVL_FULL;
            cnt_q      <= '0;
            idx_p1_q   <= '0;
            blank_p1_q <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            cnt_q      <= cnt_d;
            idx_p1_q   <= idx_p1_d;
            blank_p1_q <= Blank;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign FadeBusy  = (state_q == FADING_OUT) || (state_q == FADING_IN);
    assign FadeLevel = lvl_q;
    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: selection, palette/blanking pipeline and fade FSM.
module tb_layer_compositor;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        FrameStart;
    logic        Blank;
    logic [23:0] LayerPixel;
    logic [7:0]  LayerDepth;
    logic [5:0]  BgPixel;
    logic        MapForce;
    logic        FadeStart;
    logic        FadeDir;
    logic        FadeBusy;
    logic [4:0]  FadeLevel;
    logic [7:0]  Red, Green, Blue;

    int checks = 0;
    int errors = 0;

    layer_compositor #(
        .NUM_LAYERS(4), .IDX_W(6), .DEPTH_W(2), .LVL_W(4), .FADE_RATE(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .FrameStart(FrameStart), .Blank(Blank),
        .LayerPixel(LayerPixel), .LayerDepth(LayerDepth), .BgPixel(BgPixel),
        .MapForce(MapForce), .FadeStart(FadeStart), .FadeDir(FadeDir),
        .FadeBusy(FadeBusy), .FadeLevel(FadeLevel),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        tick();
    endtask

    task automatic fade_cmd(input logic dir);
        FadeStart = 1'b1;
        FadeDir   = dir;
        tick();
        FadeStart = 1'b0;
    endtask

    initial begin
        Reset      = 1'b0;
        FrameStart = 1'b0;
        Blank      = 1'b1;
        LayerPixel = {6'd1, 6'd1, 6'd1, 6'd1};
        LayerDepth = 8'h00;
        BgPixel    = 6'd0;
        MapForce   = 1'b0;
        FadeStart  = 1'b0;
        FadeDir    = 1'b0;

        // 1: reset
        tick(); tick(); tick();
        check("reset_rgb", {Red, Green, Blue}, 24'h000000);
        check("reset_level", FadeLevel, 5'd16);
        check("reset_busy", FadeBusy, 1'b0);
        Reset = 1'b1;

        // 2: depth winner, then tie to lowest layer
        LayerPixel = {6'd0, 6'd9, 6'd0, 6'd5};
        LayerDepth = {2'd0, 2'd2, 2'd0, 2'd1};
        tick();
        check("latency_one_clk", {Red, Green, Blue}, 24'h000000);
        tick();
        check("deepest_idx9", {Red, Green, Blue}, 24'h27D949);
        LayerDepth = {2'd0, 2'd2, 2'd0, 2'd2};
        tick(); tick();
        check("tie_idx5", {Red, Green, Blue}, 24'h17E945);

        // 3: map overlay
        LayerPixel = {6'd0, 6'd0, 6'd7, 6'd0};
        LayerDepth = {2'd0, 2'd0, 2'd1, 2'd0};
        MapForce   = 1'b1;
        BgPixel    = 6'd3;
        tick(); tick();
        check("mapforce_bg3", {Red, Green, Blue}, 24'h0FF1C3);
        LayerDepth = {2'd0, 2'd0, 2'd3, 2'd0};
        tick(); tick();
        check("top_layer_idx7", {Red, Green, Blue}, 24'h1FE1C7);

        // 4: all transparent, then blanking
        MapForce   = 1'b0;
        LayerPixel = 24'h0;
        BgPixel    = 6'd12;
        tick(); tick();
        check("bg_idx12", {Red, Green, Blue}, 24'h33CD0C);
        Blank = 1'b0;
        tick();
        check("blank_one_clk", {Red, Green, Blue}, 24'h33CD0C);
        tick();
        check("blank_rgb0", {Red, Green, Blue}, 24'h000000);
        Blank = 1'b1;

        // 5: fade out over 32 frames
        BgPixel = 6'd63;
        tick(); tick();
        check("full_idx63", {Red, Green, Blue}, 24'hFF01FF);
        fade_cmd(1'b0);
        check("fade_out_busy", FadeBusy, 1'b1);
        check("fade_out_level", FadeLevel, 5'd16);
        frame_pulse();
        check("first_frame_no_step", FadeLevel, 5'd16);
        frame_pulse();
        check("second_frame_step", FadeLevel, 5'd15);
        check("level15_rgb", {Red, Green, Blue}, 24'hEF00EF);
        for (int i = 0; i < 14; i++) frame_pulse();
        check("level8", FadeLevel, 5'd8);
        check("level8_rgb", {Red, Green, Blue}, 24'h7F007F);
        for (int i = 0; i < 15; i++) frame_pulse();
        check("level1_busy", FadeBusy, 1'b1);
        check("level1", FadeLevel, 5'd1);
        frame_pulse();
        check("dark_level", FadeLevel, 5'd0);
        check("dark_busy", FadeBusy, 1'b0);
        tick();
        check("dark_rgb", {Red, Green, Blue}, 24'h000000);
        frame_pulse(); frame_pulse();
        check("dark_stays", FadeLevel, 5'd0);

        // 6: ignored commands, fade in, reversal, reset mid-fade
        fade_cmd(1'b0);
        check("ignored_out_in_dark", FadeBusy, 1'b0);
        fade_cmd(1'b1);
        check("fade_in_busy", FadeBusy, 1'b1);
        frame_pulse(); frame_pulse();
        check("fade_in_level1", FadeLevel, 5'd1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("reset_mid_in_level", FadeLevel, 5'd16);
        check("reset_mid_in_busy", FadeBusy, 1'b0);
        fade_cmd(1'b1);
        check("ignored_in_in_bright", FadeBusy, 1'b0);
        fade_cmd(1'b0);
        for (int i = 0; i < 12; i++) frame_pulse();
        check("out_level10", FadeLevel, 5'd10);
        frame_pulse();
        FadeStart  = 1'b1;
        FadeDir    = 1'b1;
        FrameStart = 1'b1;
        tick();
        FadeStart  = 1'b0;
        FrameStart = 1'b0;
        check("reversal_level", FadeLevel, 5'd10);
        check("reversal_busy", FadeBusy, 1'b1);
        frame_pulse();
        check("reversal_cnt_cleared", FadeLevel, 5'd10);
        frame_pulse();
        check("fade_in_step_up", FadeLevel, 5'd11);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("reset_mid_fade_level", FadeLevel, 5'd16);
        check("reset_mid_fade_busy", FadeBusy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
